round_op_scheduler: RTL

//  Sequences the coefficient-rounding/packing units of the Saber coprocessor. Accepts one

---
 rtl/round_op_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/round_op_scheduler.sv
// round_op_scheduler
//   Sequences the coefficient-rounding/packing units of the Saber coprocessor.
//   It accepts one command at a time and starts the selected unit by releasing
//   that unit's reset. While the unit runs, its local read/write addresses are
//   relocated by the command base addresses onto the single data-memory port.
//   The scheduler reports completion, or a watchdog timeout if the unit never
//   finishes. The unit that is not selected is held in reset throughout.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready      command handshake (accepted on valid & ready)
//   cmd_unit                 0 = add/round unit, 1 = auxiliary pack unit
//   cmd_src_base/dst_base    read/write relocation bases
//   busy, op_done, op_err    status: running, completion pulse, sticky timeout
//   mem_raddr/waddr/wdata/we single data-memory port
//   u0_*/u1_*                per-unit reset, local addresses, data, we, done
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a command, both units held in reset
// START  | selected unit held in reset for START_CYC cycles
// RUN    | selected unit running and owning the memory port, watchdog on
// DONE   | unit reported done: one-cycle op_done
// ABORT  | watchdog expired: one-cycle op_done with op_err set
module round_op_scheduler #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 64,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_unit,
    input  logic [ADDR_W-1:0] cmd_src_base,
    input  logic [ADDR_W-1:0] cmd_dst_base,
    output logic              busy,
    output logic              op_done,
    output logic              op_err,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              u0_rst,
    output logic              u1_rst,
    input  logic [ADDR_W-1:0] u0_raddr,
    input  logic [ADDR_W-1:0] u1_raddr,
    input  logic [ADDR_W-1:0] u0_waddr,
    input  logic [ADDR_W-1:0] u1_waddr,
    input  logic [DATA_W-1:0] u0_wdata,
    input  logic [DATA_W-1:0] u1_wdata,
    input  logic              u0_we,
    input  logic              u1_we,
    input  logic              u0_done,
    input  logic              u1_done
);

    localparam int SCNT_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t              state, state_nxt;
    logic                unit_sel;
    logic [ADDR_W-1:0]   src_base;
    logic [ADDR_W-1:0]   dst_base;
    logic                op_err_q;
    logic [SCNT_W-1:0]   start_cnt;
    logic [15:0]         wdog;

    logic                sel_done;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_raddr;
    logic [ADDR_W-1:0]   sel_waddr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                accept;
    logic                run;
    logic                wdog_expire;

    // Unit mux follows the latched selection, so mem_raddr stays meaningful
    // even outside RUN.
    assign sel_done  = unit_sel ? u1_done  : u0_done;
    assign sel_we    = unit_sel ? u1_we    : u0_we;
    assign sel_raddr = unit_sel ? u1_raddr : u0_raddr;
    assign sel_waddr = unit_sel ? u1_waddr : u0_waddr;
    assign sel_wdata = unit_sel ? u1_wdata : u0_wdata;

    assign accept      = (state == S_IDLE) && cmd_valid;
    assign run         = (state == S_RUN);
    // wdog equals the index of the current RUN cycle, so the last permitted
    // RUN cycle is TIMEOUT-1.
    assign wdog_expire = (wdog == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            unit_sel  <= 1'b0;
            src_base  <= '0;
            dst_base  <= '0;
            op_err_q  <= 1'b0;
            start_cnt <= '0;
            wdog      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                unit_sel  <= cmd_unit;
                src_base  <= cmd_src_base;
                dst_base  <= cmd_dst_base;
                op_err_q  <= 1'b0;
                start_cnt <= SCNT_W'(START_CYC - 1);
            end else if (state == S_START && start_cnt != '0) begin
                start_cnt <= start_cnt - 1'b1;
            end
            if (state == S_START) begin
                wdog <= '0;
            end else if (run) begin
                wdog <= wdog + 16'd1;
            end
            if (run && state_nxt == S_ABORT) begin
                op_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        op_done   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = ~rst;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = S_START;
            end
            S_START: begin
                // A stale done from the previous run is not looked at here.
                if (start_cnt == '0) state_nxt = S_RUN;
            end
            S_RUN: begin
                // Done wins over a watchdog expiring in the same cycle.
                if (sel_done)         state_nxt = S_DONE;
                else if (wdog_expire) state_nxt = S_ABORT;
            end
            S_DONE, S_ABORT: begin
                op_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign op_err    = op_err_q;
    assign u0_rst    = rst | ~(run & ~unit_sel);
    assign u1_rst    = rst | ~(run &  unit_sel);
    assign mem_we    = run & sel_we;
    assign mem_raddr = src_base + sel_raddr;
    assign mem_waddr = dst_base + sel_waddr;
    assign mem_wdata = sel_wdata;

endmodule
